// File: rtl/sr_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_muldiv_unit_pkg
// Description : Shared definitions for the iterative multiply/divide unit.
//               - MULDIV funct7 code and the eight funct3 operation codes
//               - FSM state encoding (IDLE -> RUN -> DONE)
// Revision    : 1.0 - initial release
// ============================================================================
package sr_muldiv_unit_pkg;

    localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

    localparam logic [2:0] RVF3_MUL    = 3'b000;
    localparam logic [2:0] RVF3_MULH   = 3'b001;
    localparam logic [2:0] RVF3_MULHSU = 3'b010;
    localparam logic [2:0] RVF3_MULHU  = 3'b011;
    localparam logic [2:0] RVF3_DIV    = 3'b100;
    localparam logic [2:0] RVF3_DIVU   = 3'b101;
    localparam logic [2:0] RVF3_REM    = 3'b110;
    localparam logic [2:0] RVF3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/sr_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : sr_muldiv_step
// Description : Combinational single-bit iteration of the multiply/divide
//               datapath. Chained UNROLL times by the top level.
//               Multiply : acc = {P, multiplier}; conditional add of the
//                          multiplicand into P, then shift right by one.
//               Divide   : acc = {R, Q}; shift left, trial-subtract the
//                          divisor, keep the difference when no borrow.
// Ports       : is_div   in   1       select divide step (else multiply)
//               acc_in   in   2*XLEN  accumulator before this step
//               operand  in   XLEN    multiplicand or divisor magnitude
//               acc_out  out  2*XLEN  accumulator after this step
// Parameters  : XLEN, DIV_EN (0 removes the divider path)
// Revision    : 1.0 - initial release
// ============================================================================
module sr_muldiv_step
    import sr_muldiv_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_out
);

    logic [XLEN-1:0]   mul_addend;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    // Carry out of the partial-product add becomes the new MSB after the shift.
    assign mul_addend = acc_in[0] ? operand : '0;
    assign mul_sum    = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_in[XLEN-1:1]};

    generate
        if (DIV_EN) begin : g_div
            logic [XLEN:0]     trial;
            logic [XLEN:0]     diff;
            logic [2*XLEN-1:0] div_next;

            // R < divisor always holds, so trial < 2*divisor and diff[XLEN]
            // is a clean borrow flag.
            assign trial    = acc_in[2*XLEN-1:XLEN-1];
            assign diff     = trial - {1'b0, operand};
            assign div_next = diff[XLEN]
                            ? {trial[XLEN-1:0], acc_in[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0],  acc_in[XLEN-2:0], 1'b1};
            assign acc_out  = is_div ? div_next : mul_next;
        end else begin : g_no_div
            logic unused_is_div;
            assign unused_is_div = is_div;
            assign acc_out       = mul_next;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sr_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : sr_muldiv_unit
// Description : Iterative RV32M-style multiply/divide unit (all 8 funct3 ops).
//               Operands are captured as magnitudes; the result sign is
//               applied when the last iteration retires. Divide-by-zero and
//               signed overflow bypass the iteration and finish next cycle.
// Ports       : clk     in   1     clock
//               rst     in   1     synchronous active-high reset
//               start   in   1     operation request, sampled in IDLE only
//               op      in   3     funct3 operation code
//               srcA    in   XLEN  rs1 value
//               srcB    in   XLEN  rs2 value
//               busy    out  1     RUN or DONE
//               ready   out  1     one-cycle result-valid pulse
//               result  out  XLEN  result, held until next accepted start
// Parameters  : XLEN (even, >=8), UNROLL (1,2,4; divides XLEN)
// Config      : SR_MULDIV_DIV_EN - defined: divide/remainder supported.
//               Undefined: op[2]=1 completes next cycle with result 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_muldiv_unit
    import sr_muldiv_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  srcA,
    input  logic [XLEN-1:0]  srcB,
    output logic             busy,
    output logic             ready,
    output logic [XLEN-1:0]  result
);

    localparam int              STEPS      = XLEN / UNROLL;
    localparam int              CW         = $clog2(STEPS + 1);
    localparam logic [CW-1:0]   STEPS_INIT = CW'(STEPS);
    localparam logic [XLEN-1:0] XMIN       = {1'b1, {(XLEN-1){1'b0}}};
`ifdef SR_MULDIV_DIV_EN
    localparam bit              DIV_EN     = 1'b1;
`else
    localparam bit              DIV_EN     = 1'b0;
`endif

    md_state_t          state, state_next;
    logic [CW-1:0]      counter;
    logic [2*XLEN-1:0]  acc;
    logic [XLEN-1:0]    operand;
    logic [2:0]         op_q;
    logic               neg;

    // ---------------- operand preparation (at start) ----------------
    logic            signed_a, signed_b, sa, sb, neg_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            fast_take;
    logic [XLEN-1:0] fast_val;

    assign signed_a = (op == RVF3_MULH) || (op == RVF3_MULHSU) ||
                      (op == RVF3_DIV)  || (op == RVF3_REM);
    assign signed_b = (op == RVF3_MULH) || (op == RVF3_DIV) || (op == RVF3_REM);
    assign sa       = signed_a & srcA[XLEN-1];
    assign sb       = signed_b & srcB[XLEN-1];
    assign abs_a    = sa ? (~srcA + 1'b1) : srcA;
    assign abs_b    = sb ? (~srcB + 1'b1) : srcB;

    always_comb begin
        neg_in = 1'b0;
        case (op)
            RVF3_REM:                         neg_in = sa;
            RVF3_DIV, RVF3_MULH, RVF3_MULHSU: neg_in = sa ^ sb;
            default:                          neg_in = 1'b0;
        endcase
    end

    generate
        if (DIV_EN) begin : g_div_fast
            logic b_zero, ovf;
            assign b_zero    = (srcB == '0);
            assign ovf       = ((op == RVF3_DIV) || (op == RVF3_REM)) &&
                               (srcA == XMIN) && (srcB == '1);
            assign fast_take = op[2] & (b_zero | ovf);
            // op[1] distinguishes remainder from quotient.
            always_comb begin
                fast_val = '0;
                if (b_zero)
                    fast_val = op[1] ? srcA : '1;
                else
                    fast_val = op[1] ? '0 : XMIN;
            end
        end else begin : g_no_div_fast
            assign fast_take = op[2];
            assign fast_val  = '0;
        end
    endgenerate

    // ---------------- iteration chain ----------------
    logic [2*XLEN-1:0] chain [UNROLL+1];
    logic [2*XLEN-1:0] chain_out;

    assign chain[0]  = acc;
    assign chain_out = chain[UNROLL];

    generate
        for (genvar i = 0; i < UNROLL; i++) begin : g_step
            sr_muldiv_step #(
                .XLEN   (XLEN),
                .DIV_EN (DIV_EN)
            ) u_step (
                .is_div  (op_q[2]),
                .acc_in  (chain[i]),
                .operand (operand),
                .acc_out (chain[i+1])
            );
        end
    endgenerate

    // ---------------- sign fix-up of final iteration ----------------
    logic [XLEN-1:0] acc_hi, acc_lo, hi_neg, final_val;

    assign acc_hi = chain_out[2*XLEN-1:XLEN];
    assign acc_lo = chain_out[XLEN-1:0];
    // High half of the negated double-width product: ~hi plus the carry
    // that ripples out of the low half only when the low half is zero.
    assign hi_neg = ~acc_hi + {{(XLEN-1){1'b0}}, (acc_lo == '0)};

    always_comb begin
        final_val = '0;
        case (op_q)
            RVF3_MUL:                            final_val = acc_lo;
            RVF3_MULH, RVF3_MULHSU, RVF3_MULHU:  final_val = neg ? hi_neg : acc_hi;
            RVF3_DIV,  RVF3_DIVU:                final_val = neg ? (~acc_lo + 1'b1) : acc_lo;
            RVF3_REM,  RVF3_REMU:                final_val = neg ? (~acc_hi + 1'b1) : acc_hi;
            default:                             final_val = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= MD_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ready      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start)
                    state_next = fast_take ? MD_DONE : MD_RUN;
            end
            MD_RUN: begin
                busy = 1'b1;
                if (counter == CW'(1))
                    state_next = MD_DONE;
            end
            MD_DONE: begin
                // start is still held by the same instruction here; ignore it.
                busy       = 1'b1;
                ready      = 1'b1;
                state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            acc     <= '0;
            operand <= '0;
            op_q    <= '0;
            neg     <= 1'b0;
            result  <= '0;
        end else if (state == MD_IDLE && start) begin
            op_q <= op;
            neg  <= neg_in;
            if (op[2]) begin
                acc     <= {{XLEN{1'b0}}, abs_a};
                operand <= abs_b;
            end else begin
                acc     <= {{XLEN{1'b0}}, abs_b};
                operand <= abs_a;
            end
            if (fast_take)
                result  <= fast_val;
            else
                counter <= STEPS_INIT;
        end else if (state == MD_RUN) begin
            acc     <= chain_out;
            counter <= counter - CW'(1);
            if (counter == CW'(1))
                result <= final_val;
        end
    end

endmodule
`default_nettype wire
